// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: writeback, read, load-issue and status bundle for regfile_scoreboard
//   master: drives wr_en/wr_addr/wr_data, rd_addr, ld_issue/ld_dest; sees rd_data, rd_busy, pend_cnt, dbl_err
//   slave : the register file side of the same signals
interface regfile_scoreboard_if #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic                   ld_issue;
    logic [AW-1:0]          ld_dest;
    logic [AW:0]            pend_cnt;
    logic                   dbl_err;
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, ld_issue, ld_dest,
        input  rd_data, rd_busy, pend_cnt, dbl_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, ld_issue, ld_dest,
        output rd_data, rd_busy, pend_cnt, dbl_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read register file with per-register load-pending scoreboard
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (clears registers, busy bits, pend_cnt, dbl_err)
//   bus   : slave side of regfile_scoreboard_if (writeback, combinational reads, load issue, status)
//   Register NREGS-1 is hardwired to zero and never busy.
//   Optional REGFILE_BYPASS_EN: same-cycle writeback data/busy forwarding onto the read ports.
module regfile_scoreboard #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZREG = AW'(NREGS - 1);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_pend;
    logic             r_dbl;

    logic             w_set;
    logic             w_we;
    logic             w_dbl;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt;

    assign w_set = bus.ld_issue && bus.ld_dest != ZREG;
    assign w_we  = bus.wr_en && bus.wr_addr != ZREG;
    // a same-cycle writeback to the target makes the re-issue legal
    assign w_dbl = w_set && r_busy[bus.ld_dest] && !(bus.wr_en && bus.wr_addr == bus.ld_dest);

    // clear first so a same-register set overrides it; the count is taken from the new vector
    // so it can never drift or wrap
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wr_en)
            w_busy_nxt[bus.wr_addr] = 1'b0;
        if (w_set)
            w_busy_nxt[bus.ld_dest] = 1'b1;
        w_cnt = '0;
        for (int i = 0; i < NREGS; i++)
            w_cnt = w_cnt + (AW+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
            r_pend <= '0;
            r_dbl  <= 1'b0;
        end else begin
            if (w_we)
                r_regs[bus.wr_addr] <= bus.wr_data;
            r_busy <= w_busy_nxt;
            r_pend <= w_cnt;
            r_dbl  <= r_dbl | w_dbl;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_base;
        assign w_ra   = bus.rd_addr[k*AW +: AW];
        assign w_base = (w_ra == ZREG) ? '0 : r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
        logic w_hit;
        assign w_hit = bus.wr_en && bus.wr_addr == w_ra && w_ra != ZREG;
        assign bus.rd_data[k*WIDTH +: WIDTH] = w_hit ? bus.wr_data : w_base;
        // forwarded busy is the post-edge value: cleared by the writeback unless re-set by a load
        assign bus.rd_busy[k] = w_hit ? (bus.ld_issue && bus.ld_dest == w_ra) : r_busy[w_ra];
`else
        assign bus.rd_data[k*WIDTH +: WIDTH] = w_base;
        assign bus.rd_busy[k] = r_busy[w_ra];
`endif
    end

    assign bus.pend_cnt = r_pend;
    assign bus.dbl_err  = r_dbl;
endmodule
